sys_rst_seq: RTL

- Clock-enable/reset sequencer for the five SYS_CTRL clock domains: E-core, P-core, core link, system link, peripheral link.
- Consumes the per-domain clock-enable and reset fields of the SYS_CTRL clock/reset registers, plus PLL lock indications.
- Drives gated clock enables and active-low domain resets in a safe order: PLL lock, then clock on, then settle, then reset release.
- Runs one boot sequence after reset, then serves run-time bring-up and shutdown requests one domain at a time.

---
 rtl/sys_ctrl_pkg.sv | 25 ++
 rtl/sys_rst_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - SYS_CTRL shared domain indices, defaults and sequencer state type
package sys_ctrl_pkg;

    localparam int SYS_NUM_DOM     = 5;

    localparam int DOM_E_CORE      = 0;
    localparam int DOM_P_CORE      = 1;
    localparam int DOM_CORE_LINK   = 2;
    localparam int DOM_SYS_LINK    = 3;
    localparam int DOM_PERIPH_LINK = 4;

    typedef enum logic [1:0] {
        LOCK,
        SETTLE,
        RUN,
        HOLD
    } seq_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sys_rst_seq.sv
// rtl/sys_rst_seq.sv - clock-enable/reset sequencer for the SYS_CTRL clock domains
// Optional PLL lock timeout: define SYS_RST_SEQ_LOCK_TIMEOUT_EN.
module sys_rst_seq
    import sys_ctrl_pkg::*;
#(
    parameter int NUM_DOM      = SYS_NUM_DOM,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int SETTLE_CYC   = 8,
    parameter int HOLD_CYC     = 4
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [NUM_DOM-1:0] sw_clk_en_i,
    input  logic [NUM_DOM-1:0] sw_rst_i,
    input  logic [NUM_DOM-1:0] pll_lock_i,
    output logic [NUM_DOM-1:0] clk_en_o,
    output logic [NUM_DOM-1:0] rst_no,
    output logic               busy_o,
    output logic               done_o,
    output logic [NUM_DOM-1:0] err_o
);

    localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, SETTLE_CYC, HOLD_CYC) + 1);
    localparam int PTR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_FIRST   = PTR_W'(NUM_DOM - 1);
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DOM_E_CORE);

    seq_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DOM-1:0] clk_en_d, rst_n_d;
    logic               done_d, busy_d;
    logic [NUM_DOM-1:0] failed_q;
    logic [NUM_DOM-1:0] wanted, shut_req, bring_req;
    logic [PTR_W-1:0]   shut_idx, bring_idx;
    logic               shut_any, bring_any;
    logic               cur_wanted, cur_lock, lock_to, finish, boot;

    assign wanted     = sw_clk_en_i & ~sw_rst_i & ~failed_q;
    assign shut_req   = rst_no & (~wanted | ~pll_lock_i);
    assign bring_req  = wanted & ~rst_no;
    assign cur_wanted = wanted[ptr_q];
    assign cur_lock   = pll_lock_i[ptr_q];
    assign boot       = ~done_o;

    // Shutdowns pick the lowest index (cores first), bring-ups the highest (links first).
    always_comb begin
        shut_any  = |shut_req;
        bring_any = |bring_req;
        shut_idx  = '0;
        bring_idx = '0;
        for (int d = NUM_DOM - 1; d >= 0; d--) begin
            if (shut_req[d]) shut_idx = PTR_W'(d);
        end
        for (int d = 0; d < NUM_DOM; d++) begin
            if (bring_req[d]) bring_idx = PTR_W'(d);
        end
    end

`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic [NUM_DOM-1:0] err_q, err_set, dom_sel;

    assign lock_to = (cnt_q == LOCK_LAST);
    assign dom_sel = NUM_DOM'(1) << ptr_q;
    assign err_set = (state_q == LOCK && cur_wanted && !cur_lock && lock_to) ? dom_sel : '0;

    // A failed domain stays excluded until software drops its clock enable.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_q    <= '0;
            failed_q <= '0;
        end else begin
            failed_q <= (failed_q | err_set) & sw_clk_en_i;
            err_q    <= (err_q | err_set) & ~(rst_n_d & ~rst_no);
        end
    end

    assign err_o = err_q;
`else
    assign lock_to  = 1'b0;
    assign failed_q = '0;
    assign err_o    = '0;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= LOCK;
            ptr_q    <= PTR_FIRST;
            cnt_q    <= '0;
            clk_en_o <= '0;
            rst_no   <= '0;
            done_o   <= 1'b0;
            busy_o   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            clk_en_o <= clk_en_d;
            rst_no   <= rst_n_d;
            done_o   <= done_d;
            busy_o   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        finish  = 1'b0;
        unique case (state_q)
            LOCK: begin
                if (!cur_wanted) begin
                    finish = 1'b1;
                end else if (cur_lock) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (lock_to) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (!cur_wanted || !cur_lock || cnt_q == SETTLE_LAST) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (shut_any) begin
                    state_d = HOLD;
                    ptr_d   = shut_idx;
                    cnt_d   = '0;
                end else if (bring_any) begin
                    state_d = LOCK;
                    ptr_d   = bring_idx;
                    cnt_d   = '0;
                end
            end
        endcase
        // Leaving a domain: boot walks on to the next pointer, run-time returns to RUN.
        if (finish) begin
            cnt_d = '0;
            if (boot && ptr_q != PTR_LAST) begin
                ptr_d   = ptr_q - PTR_W'(1);
                state_d = LOCK;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        clk_en_d = clk_en_o;
        rst_n_d  = rst_no;
        done_d   = done_o;
        unique case (state_q)
            LOCK: begin
                if (!cur_wanted) clk_en_d[ptr_q] = 1'b0;
                else if (cur_lock) clk_en_d[ptr_q] = 1'b1;
            end
            SETTLE: begin
                if (!cur_wanted || !cur_lock) clk_en_d[ptr_q] = 1'b0;
                else if (cnt_q == SETTLE_LAST) rst_n_d[ptr_q] = 1'b1;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) clk_en_d[ptr_q] = 1'b0;
            end
            RUN: begin
                if (shut_any) rst_n_d[shut_idx] = 1'b0;
            end
        endcase
        if (finish && boot && ptr_q == PTR_LAST) done_d = 1'b1;
        busy_d = (state_d != RUN);
    end

endmodule
